cache_controller: RTL and testbench

//  Sequencer between the MEM stage and the 2-way read cache / SRAM controller.

---
 rtl/cache_controller.sv | 192 +++++++++++++++++++
 tb/tb_cache_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// cache_controller
//   Sequencer between the MEM stage and the 2-way read cache / SRAM controller.
//   Read hits complete combinationally in the request cycle. Read misses fetch a
//   64-bit line from SRAM, fill the cache and return the addressed word. Writes
//   are write-through: the cache line is invalidated and the word goes to SRAM.
//   'ready' low freezes the pipeline.
//
//   Optional build macro: CACHE_STATS_EN adds saturating hit/miss counters.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   MEM_R_EN, MEM_W_EN       load / store request from MEM stage
//   address, wdata           request byte address and store data
//   rdata, ready             load data and completion (freeze = ~ready)
//   cache_hit, cache_rdata   cache lookup result
//   cache_r_en, cache_w_en   cache read / invalidate enables
//   cache_addr               cache lookup / fill address
//   cache_fill, cache_line   line-valid strobe and fill line to cache
//   sram_r_en, sram_w_en     SRAM level requests, held until sram_ready
//   sram_addr, sram_wdata    latched request address and store data
//   sram_ready, sram_rdata   SRAM completion pulse and 64-bit line
//   hit_count, miss_count    read hit / miss statistics (CACHE_STATS_EN only)
module cache_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic                cache_hit,
  input  logic [DATA_W-1:0]   cache_rdata,
  output logic                cache_r_en,
  output logic                cache_w_en,
  output logic [ADDR_W-1:0]   cache_addr,
  output logic                cache_fill,
  output logic [2*DATA_W-1:0] cache_line,
  output logic                sram_r_en,
  output logic                sram_w_en,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic                sram_ready,
  input  logic [2*DATA_W-1:0] sram_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_MISS = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              sram_r_q;
  logic              sram_w_q;
  logic [DATA_W-1:0] miss_word;
  logic              wr_req;
  logic              rd_hit;
  logic              rd_miss;
  logic              miss_done;
  logic              wr_done;

  // Store wins when both enables are raised in the same cycle.
  assign wr_req    = (state == IDLE) && MEM_W_EN;
  assign rd_hit    = (state == IDLE) && MEM_R_EN && !MEM_W_EN && cache_hit;
  assign rd_miss   = (state == IDLE) && MEM_R_EN && !MEM_W_EN && !cache_hit;
  assign miss_done = (state == RD_MISS) && sram_ready;
  assign wr_done   = (state == WR_WAIT) && sram_ready;

  // Upper half of the line holds the word with addr[2] == 0.
  assign miss_word = addr_q[2] ? sram_rdata[DATA_W-1:0]
                               : sram_rdata[2*DATA_W-1:DATA_W];

  assign cache_line = sram_rdata;
  assign sram_r_en  = sram_r_q;
  assign sram_w_en  = sram_w_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

  // rdata is live on the completing cycle (hit or fill) and otherwise holds
  // the last returned word, so the MEM stage sees it without an extra cycle.
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    cache_r_en = 1'b0;
    cache_w_en = 1'b0;
    cache_addr = addr_q;
    cache_fill = 1'b0;
    rdata      = rdata_q;
    case (state)
      IDLE: begin
        cache_addr = address;
        cache_r_en = MEM_R_EN;
        cache_w_en = MEM_W_EN;
        if (MEM_W_EN) begin
          state_nxt = WR_WAIT;
        end else if (MEM_R_EN) begin
          if (cache_hit) begin
            ready = 1'b1;
            rdata = cache_rdata;
          end else begin
            state_nxt = RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        cache_r_en = 1'b1;
        if (sram_ready) begin
          cache_fill = 1'b1;
          rdata      = miss_word;
          ready      = 1'b1;
          state_nxt  = IDLE;
        end
      end
      WR_WAIT: begin
        if (sram_ready) begin
          ready     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      sram_r_q <= 1'b0;
      sram_w_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_req) begin
        addr_q   <= address;
        wdata_q  <= wdata;
        sram_w_q <= 1'b1;
      end
      if (rd_miss) begin
        addr_q   <= address;
        sram_r_q <= 1'b1;
      end
      if (rd_hit) begin
        rdata_q <= cache_rdata;
      end
      if (miss_done) begin
        rdata_q  <= miss_word;
        sram_r_q <= 1'b0;
      end
      if (wr_done) begin
        sram_w_q <= 1'b0;
      end
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit && (hit_count != '1)) begin
        hit_count <= hit_count + 1'b1;
      end
      if (rd_miss && (miss_count != '1)) begin
        miss_count <= miss_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller. Stimulus pushes the expected response
// of each request; a negedge monitor pops it when the DUT completes (ready high
// with a request present) and checks data, freeze length, fills and SRAM enables.
module tb_cache_controller;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_EN, MEM_W_EN;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          cache_hit;
  logic [DW-1:0] cache_rdata;
  logic          cache_r_en, cache_w_en;
  logic [AW-1:0] cache_addr;
  logic          cache_fill;
  logic [2*DW-1:0] cache_line;
  logic          sram_r_en, sram_w_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_ready;
  logic [2*DW-1:0] sram_rdata;
`ifdef CACHE_STATS_EN
  logic [CW-1:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_controller #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .cache_r_en(cache_r_en), .cache_w_en(cache_w_en),
    .cache_addr(cache_addr), .cache_fill(cache_fill), .cache_line(cache_line),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ready(sram_ready), .sram_rdata(sram_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] rdata;
    int          lat;
    int          fills;
    bit          saw_rd;
    bit          saw_wr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // ---------------- monitor ----------------
  int lo_cnt = 0;
  int fill_cnt = 0;
  bit saw_r = 1'b0;
  bit saw_w = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      lo_cnt = 0; fill_cnt = 0; saw_r = 1'b0; saw_w = 1'b0;
    end else if (MEM_R_EN || MEM_W_EN) begin
      if (cache_fill) fill_cnt++;
      if (sram_r_en) saw_r = 1'b1;
      if (sram_w_en) saw_w = 1'b1;
      if (ready) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          if (!e.is_wr) check("rdata", 64'(rdata), 64'(e.rdata));
          check("freeze_cycles", 64'(lo_cnt), 64'(e.lat));
          check("fill_pulses", 64'(fill_cnt), 64'(e.fills));
          check("saw_sram_r_en", 64'(saw_r), 64'(e.saw_rd));
          check("saw_sram_w_en", 64'(saw_w), 64'(e.saw_wr));
        end
        lo_cnt = 0; fill_cnt = 0; saw_r = 1'b0; saw_w = 1'b0;
      end else begin
        lo_cnt++;
        if (lo_cnt > 64) begin
          check("completion_timeout", 64'(lo_cnt), 64'd64);
          lo_cnt = 0;
        end
      end
    end else if (cache_fill) begin
      check("stray_fill", 64'(cache_fill), 64'd0);
    end
  end

  // ---------------- stimulus ----------------
  // Miss: request cycle is cycle 0, sram_ready is driven in cycle 'lat',
  // so ready stays low for exactly 'lat' cycles.
  task automatic req_read(input logic [31:0] addr, input bit hit, input logic [31:0] cdata,
                          input int lat, input logic [63:0] line, input logic [31:0] expd);
    exp_t x;
    x.is_wr = 1'b0; x.rdata = expd; x.lat = hit ? 0 : lat;
    x.fills = hit ? 0 : 1; x.saw_rd = !hit; x.saw_wr = 1'b0;
    sb.push_back(x);
    if (hit) exp_hits++; else exp_miss++;
    MEM_R_EN = 1'b1; MEM_W_EN = 1'b0; address = addr;
    cache_hit = hit; cache_rdata = cdata;
    @(posedge clk); #1;
    if (!hit) begin
      address = 32'hDEAD_BEE4;      // MEM inputs drift while frozen
      cache_hit = 1'b1;
      check("miss_sram_addr", 64'(sram_addr), 64'(addr));
      check("miss_cache_addr", 64'(cache_addr), 64'(addr));
      check("miss_sram_r_en", 64'(sram_r_en), 64'd1);
      for (int i = 1; i < lat; i++) begin
        @(posedge clk); #1;
      end
      sram_ready = 1'b1; sram_rdata = line;
      @(posedge clk); #1;
      sram_ready = 1'b0;
    end
    MEM_R_EN = 1'b0; cache_hit = 1'b0;
    #1 check("sram_r_en_after_read", 64'(sram_r_en), 64'd0);
  endtask

  task automatic req_write(input logic [31:0] addr, input logic [31:0] data,
                           input int lat, input bit both);
    exp_t x;
    x.is_wr = 1'b1; x.rdata = '0; x.lat = lat; x.fills = 0;
    x.saw_rd = 1'b0; x.saw_wr = 1'b1;
    sb.push_back(x);
    MEM_W_EN = 1'b1; MEM_R_EN = both; address = addr; wdata = data; cache_hit = 1'b0;
    #1 check("wr_cache_w_en_idle", 64'(cache_w_en), 64'd1);
    @(posedge clk); #1;
    address = 32'hDEAD_BEE0; wdata = 32'h0BAD_0BAD;
    check("wr_sram_w_en", 64'(sram_w_en), 64'd1);
    check("wr_sram_wdata", 64'(sram_wdata), 64'(data));
    check("wr_sram_addr", 64'(sram_addr), 64'(addr));
    check("wr_cache_w_en_wait", 64'(cache_w_en), 64'd0);
    for (int i = 1; i < lat; i++) begin
      @(posedge clk); #1;
    end
    sram_ready = 1'b1;
    @(posedge clk); #1;
    sram_ready = 1'b0;
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
    #1 check("sram_w_en_after_write", 64'(sram_w_en), 64'd0);
  endtask

  localparam logic [63:0] LINE = 64'hAAAA_BBBB_CCCC_DDDD;

  initial begin
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; wdata = '0;
    cache_hit = 1'b0; cache_rdata = '0; sram_ready = 1'b0; sram_rdata = '0;
    @(posedge clk); #1;
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_sram_r_en", 64'(sram_r_en), 64'd0);
    check("rst_sram_w_en", 64'(sram_w_en), 64'd0);
    check("rst_cache_fill", 64'(cache_fill), 64'd0);
    check("rst_sram_addr", 64'(sram_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 0x408 has addr[2]=0 -> upper word; 0x40C has addr[2]=1 -> lower word
    req_read(32'h0000_0408, 1'b0, '0, 5, LINE, 32'hAAAA_BBBB);
    req_read(32'h0000_040C, 1'b0, '0, 3, LINE, 32'hCCCC_DDDD);
    req_read(32'h0000_0408, 1'b1, 32'hCCCC_DDDD, 0, '0, 32'hCCCC_DDDD);
    req_write(32'h0000_0400, 32'h1234_5678, 4, 1'b0);
    req_write(32'h0000_0500, 32'hCAFE_F00D, 2, 1'b1);
    req_read(32'h0000_0010, 1'b1, 32'h1111_2222, 0, '0, 32'h1111_2222);
    check("rdata_hold_idle", 64'(rdata), 64'h1111_2222);

    // sram_ready with no transaction in flight must be ignored
    sram_ready = 1'b1; sram_rdata = LINE;
    #1 check("idle_sram_ready_fill", 64'(cache_fill), 64'd0);
    check("idle_sram_ready_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    sram_ready = 1'b0;
    check("idle_sram_ready_r_en", 64'(sram_r_en), 64'd0);

    // reset in the middle of a miss
    MEM_R_EN = 1'b1; address = 32'h0000_0600; cache_hit = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_sram_r_en", 64'(sram_r_en), 64'd1);
    MEM_R_EN = 1'b0; rst = 1'b1; sram_ready = 1'b1;
    exp_hits = 0; exp_miss = 0;
    #1;
    check("mid_rst_sram_r_en", 64'(sram_r_en), 64'd0);
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_fill", 64'(cache_fill), 64'd0);
    check("mid_rst_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; sram_ready = 1'b0;
    @(posedge clk); #1;

    req_read(32'h0000_0408, 1'b0, '0, 2, LINE, 32'hAAAA_BBBB);
    req_read(32'h0000_040C, 1'b0, '0, 4, LINE, 32'hCCCC_DDDD);
    req_read(32'h0000_0020, 1'b1, 32'h0000_0001, 0, '0, 32'h0000_0001);
    req_read(32'h0000_0024, 1'b1, 32'h0000_0002, 0, '0, 32'h0000_0002);
    req_read(32'h0000_0028, 1'b1, 32'h0000_0003, 0, '0, 32'h0000_0003);

`ifdef CACHE_STATS_EN
    check("hit_count", 64'(hit_count), 64'(exp_hits));
    check("miss_count", 64'(miss_count), 64'(exp_miss));
    // saturate hit counter: 2^CW + 5 consecutive hits
    MEM_R_EN = 1'b1; cache_hit = 1'b1; cache_rdata = 32'h5A5A_5A5A; address = 32'h40;
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      exp_t x;
      x.is_wr = 1'b0; x.rdata = 32'h5A5A_5A5A; x.lat = 0; x.fills = 0;
      x.saw_rd = 1'b0; x.saw_wr = 1'b0;
      sb.push_back(x);
      @(posedge clk); #1;
    end
    MEM_R_EN = 1'b0; cache_hit = 1'b0;
    #1;
    check("hit_count_sat", 64'(hit_count), 64'hFFFF);
    check("miss_count_after_sat", 64'(miss_count), 64'd2);
`endif

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
